// File: rtl/exec_unit_pipe.sv
// exec_unit_pipe: execute stage sitting between decode and the register file.
// Accepts one decoded instruction per valid/ready handshake. Single-cycle ops
// (add, sub, and/or/xor, logical shifts) write back one cycle after accept.
// MUL runs an unsigned shift-add over DATA_W cycles with o_ready held low.
//
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_valid / o_ready       instruction handshake (o_ready high iff IDLE)
//   i_opcode                operation select
//   i_srcdata_1/2           operand A, operand B (or shift amount)
//   i_destadd               destination register address
//   o_write_en              one-cycle write-back strobe
//   o_write_add/o_write_data write-back address/data (hold last value)
//   o_zero, o_carry         flags of the last written result
//   o_illegal               one-cycle pulse for an accepted undefined opcode
module exec_unit_pipe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned SH_W   = $clog2(DATA_W)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [3:0]        i_opcode,
  input  logic [DATA_W-1:0] i_srcdata_1,
  input  logic [DATA_W-1:0] i_srcdata_2,
  input  logic [ADDR_W-1:0] i_destadd,
  output logic              o_write_en,
  output logic [ADDR_W-1:0] o_write_add,
  output logic [DATA_W-1:0] o_write_data,
  output logic              o_zero,
  output logic              o_carry,
  output logic              o_illegal
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(DATA_W - 1);

  typedef enum logic [3:0] {
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_AND = 4'b0011,
    OP_SHL = 4'b0100,
    OP_OR  = 4'b0101,
    OP_XOR = 4'b0110,
    OP_MUL = 4'b0111,
    OP_SHR = 4'b1000
  } op_e;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e              state_q, state_d;
  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   wadd_q, wadd_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                zero_q, zero_d;
  logic                carry_q, carry_d;
  logic                illegal_q, illegal_d;

  logic                accept;
  logic [SH_W-1:0]     sh_amt;
  logic [DATA_W:0]     sum, diff, shl_w, shr_w;
  logic [2*DATA_W-1:0] acc_next;
  logic [DATA_W-1:0]   res;
  logic                cy, wr;

  assign o_ready = (state_q == S_IDLE);
  assign accept  = i_valid & o_ready;
  assign sh_amt  = i_srcdata_2[SH_W-1:0];
  assign sum     = {1'b0, i_srcdata_1} + {1'b0, i_srcdata_2};
  // Bit DATA_W of the extended difference is the unsigned borrow.
  assign diff    = {1'b0, i_srcdata_1} - {1'b0, i_srcdata_2};
  // One guard bit on the exit side catches the last bit shifted out;
  // it stays 0 for a zero shift amount.
  assign shl_w   = {1'b0, i_srcdata_1} << sh_amt;
  assign shr_w   = {i_srcdata_1, 1'b0} >> sh_amt;
  assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    dest_d    = dest_q;
    cnt_d     = cnt_q;
    we_d      = 1'b0;
    wadd_d    = wadd_q;
    wdata_d   = wdata_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    illegal_d = 1'b0;
    res       = '0;
    cy        = 1'b0;
    wr        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          wr = 1'b1;
          case (i_opcode)
            OP_ADD: {cy, res} = sum;
            OP_SUB: {cy, res} = diff;
            OP_AND: res = i_srcdata_1 & i_srcdata_2;
            OP_OR:  res = i_srcdata_1 | i_srcdata_2;
            OP_XOR: res = i_srcdata_1 ^ i_srcdata_2;
            OP_SHL: {cy, res} = shl_w;
            OP_SHR: {res, cy} = shr_w;
            OP_MUL: begin
              wr                   = 1'b0;
              state_d              = S_BUSY;
              mcand_d              = '0;
              mcand_d[DATA_W-1:0]  = i_srcdata_1;
              mplier_d             = i_srcdata_2;
              acc_d                = '0;
              dest_d               = i_destadd;
              cnt_d                = '0;
            end
            default: begin
              wr        = 1'b0;
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      S_BUSY: begin
        // One partial product per cycle: multiplicand walks left,
        // multiplier walks right so bit 0 is always the current digit.
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_IT) begin
          wr      = 1'b1;
          res     = acc_next[DATA_W-1:0];
          cy      = |acc_next[2*DATA_W-1:DATA_W];
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wr) begin
      we_d    = 1'b1;
      wadd_d  = (state_q == S_BUSY) ? dest_q : i_destadd;
      wdata_d = res;
      zero_d  = (res == '0);
      carry_d = cy;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      dest_q    <= '0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      wadd_q    <= '0;
      wdata_q   <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mplier_q  <= mplier_d;
      dest_q    <= dest_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      wadd_q    <= wadd_d;
      wdata_q   <= wdata_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      illegal_q <= illegal_d;
    end
  end

  assign o_write_en   = we_q;
  assign o_write_add  = wadd_q;
  assign o_write_data = wdata_q;
  assign o_zero       = zero_q;
  assign o_carry      = carry_q;
  assign o_illegal    = illegal_q;

endmodule

// File: tb/tb_exec_unit_pipe.sv
// Self-checking bench for exec_unit_pipe (DATA_W=8, ADDR_W=4).
module tb_exec_unit_pipe;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic          ready;
  logic [3:0]    opcode;
  logic [DW-1:0] a, b;
  logic [AW-1:0] dest;
  logic          we;
  logic [AW-1:0] wadd;
  logic [DW-1:0] wdata;
  logic          zero, carry, illegal;

  exec_unit_pipe #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .o_ready(ready),
    .i_opcode(opcode), .i_srcdata_1(a), .i_srcdata_2(b), .i_destadd(dest),
    .o_write_en(we), .o_write_add(wadd), .o_write_data(wdata),
    .o_zero(zero), .o_carry(carry), .o_illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] add;
    logic [DW-1:0] data;
    logic          zero;
    logic          carry;
  } wb_t;

  wb_t sb[$];
  wb_t exp_wb;
  wb_t last_wb;
  int  tests = 0;
  int  fails = 0;

  // Reference behaviour: arithmetic on wide integers, shifts one bit at a time.
  function automatic wb_t model(logic [3:0] op, logic [DW-1:0] x, logic [DW-1:0] y,
                                logic [AW-1:0] d);
    wb_t          m;
    int unsigned  r;
    int unsigned  amt;
    logic         c;
    logic [DW-1:0] s;
    r = 0;
    c = 1'b0;
    case (op)
      4'b0001: begin r = 32'(x) + 32'(y); c = (r > 255); end
      4'b0010: begin r = (32'(x) + 256 - 32'(y)) % 256; c = (x < y); end
      4'b0011: r = 32'(x & y);
      4'b0101: r = 32'(x | y);
      4'b0110: r = 32'(x ^ y);
      4'b0100: begin
        s = x; amt = 32'(y) % 8;
        for (int unsigned i = 0; i < amt; i++) begin c = s[7]; s = {s[6:0], 1'b0}; end
        r = 32'(s);
      end
      4'b1000: begin
        s = x; amt = 32'(y) % 8;
        for (int unsigned i = 0; i < amt; i++) begin c = s[0]; s = {1'b0, s[7:1]}; end
        r = 32'(s);
      end
      4'b0111: begin r = 32'(x) * 32'(y); c = (r > 255); end
      default: r = 0;
    endcase
    m.add   = d;
    m.data  = r[7:0];
    m.zero  = (r[7:0] == 8'h00);
    m.carry = c;
    return m;
  endfunction

  task automatic drive(input logic [3:0] op, input logic [DW-1:0] x,
                       input logic [DW-1:0] y, input logic [AW-1:0] d, input bit push);
    valid = 1'b1; opcode = op; a = x; b = y; dest = d;
    if (push) sb.push_back(model(op, x, y, d));
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; opcode = '0; a = '0; b = '0; dest = '0;
    tick(); tick();
    tests++;
    if ({ready, we, wadd, wdata, zero, carry, illegal} !== {1'b1, 1'b0, 4'h0, 8'h00, 3'b000}) begin
      fails++;
      $display("FAIL reset_state got rdy=%b we=%b add=%h data=%h z=%b c=%b ill=%b exp 1 0 0 00 0 0 0",
               ready, we, wadd, wdata, zero, carry, illegal);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (we !== 1'b0 || ready !== 1'b1) begin
      fails++; $display("FAIL post_reset_idle got we=%b rdy=%b exp we=0 rdy=1", we, ready);
    end
  endtask

  task automatic test_add();
    drive(4'b0001, 8'hF0, 8'h20, 4'd3, 1);
    tick();
    valid = 1'b0;
    tests++;
    if (we !== 1'b1 || sb.size() == 0) begin
      fails++; $display("FAIL add_we got=%b exp=1", we);
    end else begin
      exp_wb = sb.pop_front();
      tests++;
      if ({wadd, wdata, zero, carry} !== exp_wb || exp_wb !== {4'd3, 8'h10, 1'b0, 1'b1}) begin
        fails++; $display("FAIL add_result got=%h/%h/%b/%b exp=%h/%h/%b/%b", wadd, wdata, zero, carry,
                          exp_wb.add, exp_wb.data, exp_wb.zero, exp_wb.carry);
      end
    end
    tick();
    tests++;
    if (we !== 1'b0) begin fails++; $display("FAIL add_we_drop got=%b exp=0", we); end
  endtask

  task automatic test_sub();
    drive(4'b0010, 8'h05, 8'h05, 4'd1, 1);
    tick();
    drive(4'b0010, 8'h03, 8'h04, 4'd2, 1);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (we !== 1'b1 || sb.size() == 0) begin
        fails++; $display("FAIL sub%0d_we got=%b exp=1", k, we);
      end else begin
        exp_wb = sb.pop_front();
        tests++;
        if ({wadd, wdata, zero, carry} !== exp_wb) begin
          fails++; $display("FAIL sub%0d_result got=%h/%h/%b/%b exp=%h/%h/%b/%b", k, wadd, wdata, zero,
                            carry, exp_wb.add, exp_wb.data, exp_wb.zero, exp_wb.carry);
        end
      end
      if (k == 0) begin tick(); valid = 1'b0; end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0]    ops [3] = '{4'b0110, 4'b0100, 4'b1000};
    logic [DW-1:0] as  [3] = '{8'hAA, 8'h81, 8'h81};
    logic [DW-1:0] bs  [3] = '{8'hFF, 8'h01, 8'h09};
    drive(ops[0], as[0], bs[0], 4'd4, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k < 2) drive(ops[k+1], as[k+1], bs[k+1], AW'(5 + k), 1);
      else valid = 1'b0;
      tests++;
      if (we !== 1'b1 || sb.size() == 0) begin
        fails++; $display("FAIL b2b%0d_we got=%b exp=1", k, we);
      end else begin
        exp_wb = sb.pop_front();
        tests++;
        if ({wadd, wdata, zero, carry} !== exp_wb) begin
          fails++; $display("FAIL b2b%0d_result got=%h/%h/%b/%b exp=%h/%h/%b/%b", k, wadd, wdata, zero,
                            carry, exp_wb.add, exp_wb.data, exp_wb.zero, exp_wb.carry);
        end
      end
    end
    tick();
    tests++;
    if (we !== 1'b0) begin fails++; $display("FAIL b2b_we_drop got=%b exp=0", we); end
  endtask

  task automatic test_mul();
    int low_cycles = 0;
    drive(4'b0111, 8'h10, 8'h11, 4'd7, 1);
    tick();
    // Held instruction: must not be taken while busy.
    drive(4'b0001, 8'h01, 8'h02, 4'd5, 1);
    for (int k = 0; k < 8; k++) begin
      if (ready === 1'b0) low_cycles++;
      tests++;
      if (we !== 1'b0) begin fails++; $display("FAIL mul_busy_we cycle=%0d got=%b exp=0", k, we); end
      tick();
    end
    tests++;
    if (low_cycles != 8) begin fails++; $display("FAIL mul_ready_low got=%0d exp=8", low_cycles); end
    tests++;
    if (we !== 1'b1 || ready !== 1'b1 || sb.size() == 0) begin
      fails++; $display("FAIL mul_pulse got we=%b rdy=%b exp we=1 rdy=1", we, ready);
    end else begin
      exp_wb = sb.pop_front();
      tests++;
      if ({wadd, wdata, zero, carry} !== exp_wb) begin
        fails++; $display("FAIL mul_result got=%h/%h/%b/%b exp=%h/%h/%b/%b", wadd, wdata, zero, carry,
                          exp_wb.add, exp_wb.data, exp_wb.zero, exp_wb.carry);
      end
    end
    tick();
    valid = 1'b0;
    tests++;
    if (we !== 1'b1 || sb.size() == 0) begin
      fails++; $display("FAIL held_accept_we got=%b exp=1", we);
    end else begin
      exp_wb = sb.pop_front();
      tests++;
      if ({wadd, wdata, zero, carry} !== exp_wb) begin
        fails++; $display("FAIL held_result got=%h/%h/%b/%b exp=%h/%h/%b/%b", wadd, wdata, zero, carry,
                          exp_wb.add, exp_wb.data, exp_wb.zero, exp_wb.carry);
      end
      last_wb = exp_wb;
    end
    tick();
  endtask

  task automatic test_illegal();
    // Leave carry=1 so an unwanted flag update would be visible.
    drive(4'b0010, 8'h03, 8'h04, 4'd2, 1);
    tick();
    valid = 1'b0;
    last_wb = sb.pop_front();
    tests++;
    if (we !== 1'b1 || {wadd, wdata, zero, carry} !== last_wb) begin
      fails++; $display("FAIL pre_illegal_result got we=%b %h/%h/%b/%b exp we=1 %h/%h/%b/%b", we, wadd,
                        wdata, zero, carry, last_wb.add, last_wb.data, last_wb.zero, last_wb.carry);
    end
    for (int k = 0; k < 2; k++) begin
      drive((k == 0) ? 4'b1111 : 4'b0000, 8'h00, 8'h00, 4'd9, 0);
      tick();
      valid = 1'b0;
      tests++;
      if (illegal !== 1'b1 || we !== 1'b0) begin
        fails++; $display("FAIL illegal%0d_pulse got ill=%b we=%b exp ill=1 we=0", k, illegal, we);
      end
      tests++;
      if ({wadd, wdata, zero, carry} !== last_wb) begin
        fails++; $display("FAIL illegal%0d_hold got=%h/%h/%b/%b exp=%h/%h/%b/%b", k, wadd, wdata, zero,
                          carry, last_wb.add, last_wb.data, last_wb.zero, last_wb.carry);
      end
      tick();
      tests++;
      if (illegal !== 1'b0) begin fails++; $display("FAIL illegal%0d_drop got=%b exp=0", k, illegal); end
    end
  endtask

  task automatic test_reset_mid_mul();
    int pulses = 0;
    drive(4'b0111, 8'hFF, 8'hFF, 4'd9, 0);
    tick();
    valid = 1'b0;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({ready, we, wadd, wdata, zero, carry, illegal} !== {1'b1, 1'b0, 4'h0, 8'h00, 3'b000}) begin
      fails++;
      $display("FAIL async_reset got rdy=%b we=%b add=%h data=%h z=%b c=%b ill=%b exp 1 0 0 00 0 0 0",
               ready, we, wadd, wdata, zero, carry, illegal);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (we !== 1'b0) pulses++;
    end
    tests++;
    if (pulses != 0 || ready !== 1'b1) begin
      fails++; $display("FAIL abort_no_write got pulses=%0d rdy=%b exp pulses=0 rdy=1", pulses, ready);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_mul();
    test_illegal();
    test_reset_mid_mul();
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_drain got=%0d exp=0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
